// File: rtl/apu_reg_writer.sv
// apu_reg_writer: register-write front end for the APU triangle channel.
// Parses an (address, data) byte stream, holds $4008/$400A/$400B, pulses
// reg_event after each $400B write and generates the quarter-frame tick,
// whose phase is reset by any $4017 data write.
// Build option: define APU_RESYNC_TIMEOUT_EN to abandon a pending write
// when the data byte does not arrive within TIMEOUT_CYCLES clocks.
module apu_reg_writer #(
   parameter int CLK_DIV        = 7457,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] reg_4008,
   output logic [7:0] reg_400A,
   output logic [7:0] reg_400B,
   output logic       reg_event,
   output logic       enable_240hz,
   output logic       frame_error
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [4:0]  OFF_4008 = 5'h08;
   localparam logic [4:0]  OFF_400A = 5'h0A;
   localparam logic [4:0]  OFF_400B = 5'h0B;
   localparam logic [4:0]  OFF_4017 = 5'h17;

   typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

   state_t      state_r;
   state_t      state_s;
   logic [4:0]  offset_r;
   logic [4:0]  offset_s;
   logic        addr_ok_s;
   logic        wr_s;
   logic        err_s;
   logic        load_s;
   logic        expire_s;
   logic        phase_rst_s;
   logic [7:0]  reg_4008_r;
   logic [7:0]  reg_400A_r;
   logic [7:0]  reg_400B_r;
   logic        reg_event_r;
   logic        frame_error_r;
   logic        tick_r;
   logic [15:0] div_cnt_r;

   // Address bytes carry bit 7 set and an offset no higher than $17.
   assign addr_ok_s   = rx_data[7] && (rx_data[6:0] <= 7'h17);
   assign phase_rst_s = wr_s && (offset_r == OFF_4017);

`ifdef APU_RESYNC_TIMEOUT_EN
   localparam logic [15:0] TMO_INIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] tmo_cnt_r;

   // Expiry is the DATA cycle whose decrement would reach zero; a byte in
   // that same cycle still wins and is taken as data.
   assign expire_s = (state_r == DATA) && !rx_valid && (tmo_cnt_r == 16'd1);

   // Timeout counter: loaded on an accepted address, counts silent DATA cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_r <= 16'd0;
      end else if (load_s) begin
         tmo_cnt_r <= TMO_INIT;
      end else if ((state_r == DATA) && !rx_valid && (tmo_cnt_r != 16'd0)) begin
         tmo_cnt_r <= tmo_cnt_r - 16'd1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   // Without the timeout build option DATA waits indefinitely.
   logic unused_tmo_s;
   assign unused_tmo_s = (TIMEOUT_CYCLES != 0);
   assign expire_s     = 1'b0;
`endif

   // Next-state and write/error decode for the address/data parser.
   always_comb begin
      state_s  = state_r;
      offset_s = offset_r;
      wr_s     = 1'b0;
      err_s    = 1'b0;
      load_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (rx_valid) begin
               if (addr_ok_s) begin
                  offset_s = rx_data[4:0];
                  load_s   = 1'b1;
                  state_s  = DATA;
               end else begin
                  err_s   = 1'b1;
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         DATA: begin
            if (rx_valid) begin
               wr_s    = 1'b1;
               state_s = IDLE;
            end else if (expire_s) begin
               err_s   = 1'b1;
               state_s = IDLE;
            end else begin
               state_s = DATA;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Parser state and latched register offset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         offset_r <= 5'd0;
      end else begin
         state_r  <= state_s;
         offset_r <= offset_s;
      end
   end

   // Triangle registers and the event/error strobes, all registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_4008_r    <= 8'h00;
         reg_400A_r    <= 8'h00;
         reg_400B_r    <= 8'h00;
         reg_event_r   <= 1'b0;
         frame_error_r <= 1'b0;
      end else begin
         reg_event_r   <= wr_s && (offset_r == OFF_400B);
         frame_error_r <= err_s;
         if (wr_s && (offset_r == OFF_4008)) begin
            reg_4008_r <= rx_data;
         end
         if (wr_s && (offset_r == OFF_400A)) begin
            reg_400A_r <= rx_data;
         end
         if (wr_s && (offset_r == OFF_400B)) begin
            reg_400B_r <= rx_data;
         end
      end
   end

   // Quarter-frame divider; a $4017 write restarts the phase and suppresses
   // a tick that would otherwise fall on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= 16'd0;
         tick_r    <= 1'b0;
      end else if (phase_rst_s) begin
         div_cnt_r <= 16'd0;
         tick_r    <= 1'b0;
      end else if (div_cnt_r == DIV_LAST) begin
         div_cnt_r <= 16'd0;
         tick_r    <= 1'b1;
      end else begin
         div_cnt_r <= div_cnt_r + 16'd1;
         tick_r    <= 1'b0;
      end
   end

   assign reg_4008     = reg_4008_r;
   assign reg_400A     = reg_400A_r;
   assign reg_400B     = reg_400B_r;
   assign reg_event    = reg_event_r;
   assign enable_240hz = tick_r;
   assign frame_error  = frame_error_r;

endmodule

// File: tb/tb_apu_reg_writer.sv
// tb_apu_reg_writer: randomized and directed bench for apu_reg_writer with a
// transaction-level reference model updated on every clock edge.
module tb_apu_reg_writer;

   localparam int CLK_DIV = 8;
   localparam int TMO     = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] reg_4008;
   logic [7:0] reg_400A;
   logic [7:0] reg_400B;
   logic       reg_event;
   logic       enable_240hz;
   logic       frame_error;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // reference model state
   int         edge_no = 0;
   int         anchor  = 0;
   bit         pend    = 1'b0;
   int         moff    = 0;
   int         mwait   = 0;
   logic [7:0] m4008   = 8'h00;
   logic [7:0] m400A   = 8'h00;
   logic [7:0] m400B   = 8'h00;
   bit         mev     = 1'b0;
   bit         merr    = 1'b0;
   bit         mtick   = 1'b0;

   apu_reg_writer #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .reg_4008     (reg_4008),
      .reg_400A     (reg_400A),
      .reg_400B     (reg_400B),
      .reg_event    (reg_event),
      .enable_240hz (enable_240hz),
      .frame_error  (frame_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
      end
   endtask

   // Model: what a clock edge does given the inputs presented before it.
   task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
      bit force_ph;
      force_ph = 1'b0;
      edge_no++;
      if (r) begin
         m4008 = 8'h00; m400A = 8'h00; m400B = 8'h00;
         pend = 1'b0; mev = 1'b0; merr = 1'b0; mtick = 1'b0;
         anchor = edge_no;
      end else begin
         mev  = 1'b0;
         merr = 1'b0;
         if (!pend) begin
            if (v) begin
               if (d >= 8'h80 && d <= 8'h97) begin
                  pend  = 1'b1;
                  moff  = int'(d) - 128;
                  mwait = 0;
               end else begin
                  merr = 1'b1;
               end
            end
         end else if (v) begin
            pend = 1'b0;
            if (moff == 8) m4008 = d;
            else if (moff == 10) m400A = d;
            else if (moff == 11) begin
               m400B = d;
               mev   = 1'b1;
            end else if (moff == 23) force_ph = 1'b1;
         end else begin
`ifdef APU_RESYNC_TIMEOUT_EN
            mwait++;
            if (mwait == TMO) begin
               pend = 1'b0;
               merr = 1'b1;
            end
`endif
         end
         if (force_ph) begin
            anchor = edge_no;
            mtick  = 1'b0;
         end else begin
            mtick = ((edge_no - anchor) % CLK_DIV == 0);
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [7:0] d);
      rst      = r;
      rx_valid = v;
      rx_data  = d;
      @(posedge clk);
      model_edge(r, v, d);
      #1;
      rst      = 1'b0;
      rx_valid = 1'b0;
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_4008", reg_4008, m4008);
         check("cyc_400A", reg_400A, m400A);
         check("cyc_400B", reg_400B, m400B);
         check("cyc_event", {7'd0, reg_event}, {7'd0, mev});
         check("cyc_tick", {7'd0, enable_240hz}, {7'd0, mtick});
         check("cyc_ferr", {7'd0, frame_error}, {7'd0, merr});
      end
   end

   initial begin
      logic [7:0] b;
      int         r;
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      step(1'b1, 1'b0, 8'h00);
      chk_en = 1'b1;

      // reset state, then idle: ticks in cycles 8, 16, 24
      step(1'b1, 1'b0, 8'h00);
      check("rst_4008", reg_4008, 8'h00);
      check("rst_400A", reg_400A, 8'h00);
      check("rst_400B", reg_400B, 8'h00);
      check("rst_ferr", {7'd0, frame_error}, 8'h00);
      for (int k = 1; k <= 24; k++) begin
         step(1'b0, 1'b0, 8'h00);
         check("idle_tick", {7'd0, enable_240hz}, (k % 8 == 0) ? 8'h01 : 8'h00);
         check("idle_event", {7'd0, reg_event}, 8'h00);
      end

      // $400B write with event, then $4008 without
      step(1'b0, 1'b1, 8'h8B);
      check("400B_addr_ev", {7'd0, reg_event}, 8'h00);
      step(1'b0, 1'b1, 8'h0D);
      check("400B_val", reg_400B, 8'h0D);
      check("400B_ev", {7'd0, reg_event}, 8'h01);
      check("model_400B", m400B, 8'h0D);
      step(1'b0, 1'b0, 8'h00);
      check("400B_ev_off", {7'd0, reg_event}, 8'h00);
      step(1'b0, 1'b1, 8'h88);
      step(1'b0, 1'b1, 8'hFF);
      check("4008_val", reg_4008, 8'hFF);
      check("4008_noev", {7'd0, reg_event}, 8'h00);

      // rejected address bytes
      step(1'b0, 1'b1, 8'h0B);
      check("rej_0B", {7'd0, frame_error}, 8'h01);
      step(1'b0, 1'b1, 8'h98);
      check("rej_98", {7'd0, frame_error}, 8'h01);
      check("rej_400B", reg_400B, 8'h0D);
      check("rej_400A", reg_400A, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      check("rej_clear", {7'd0, frame_error}, 8'h00);
      step(1'b0, 1'b1, 8'h8A);
      step(1'b0, 1'b1, 8'h33);
      check("idle_after_rej", reg_400A, 8'h33);

`ifdef APU_RESYNC_TIMEOUT_EN
      step(1'b0, 1'b1, 8'h8A);
      for (int i = 1; i <= TMO; i++) begin
         step(1'b0, 1'b0, 8'h00);
         check("tmo_err", {7'd0, frame_error}, (i == TMO) ? 8'h01 : 8'h00);
      end
      step(1'b0, 1'b1, 8'h55);
      check("tmo_55_rej", {7'd0, frame_error}, 8'h01);
      check("tmo_400A", reg_400A, 8'h33);
      step(1'b0, 1'b1, 8'h8A);
      for (int i = 1; i < TMO; i++) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h55);
      check("tmo_edge_val", reg_400A, 8'h55);
      check("tmo_edge_err", {7'd0, frame_error}, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      check("tmo_edge_err2", {7'd0, frame_error}, 8'h00);
`else
      step(1'b0, 1'b1, 8'h8A);
      for (int i = 1; i <= TMO + 4; i++) begin
         step(1'b0, 1'b0, 8'h00);
         check("wait_noerr", {7'd0, frame_error}, 8'h00);
      end
      step(1'b0, 1'b1, 8'h55);
      check("wait_val", reg_400A, 8'h55);
`endif

      // $4017 data write landing on terminal count
      step(1'b1, 1'b0, 8'h00);
      for (int k = 1; k <= 16; k++) begin
         if (k == 7) step(1'b0, 1'b1, 8'h97);
         else if (k == 8) step(1'b0, 1'b1, 8'h00);
         else step(1'b0, 1'b0, 8'h00);
         if (k == 8) check("ph_suppress", {7'd0, enable_240hz}, 8'h00);
         if (k == 16) check("ph_next", {7'd0, enable_240hz}, 8'h01);
      end

      // reset while waiting for data
      step(1'b0, 1'b1, 8'h8B);
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h20);
      check("rstdata_err", {7'd0, frame_error}, 8'h01);
      check("rstdata_400B", reg_400B, 8'h00);
      check("rstdata_ev", {7'd0, reg_event}, 8'h00);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (r < 8) begin
            repeat ($urandom_range(10, 20)) step(1'b0, 1'b0, 8'($urandom));
         end else if (r < 50) begin
            step(1'b0, 1'b0, 8'($urandom));
         end else begin
            case ($urandom_range(0, 4))
               0: begin
                  case ($urandom_range(0, 3))
                     0: b = 8'h88;
                     1: b = 8'h8A;
                     2: b = 8'h8B;
                     default: b = 8'h97;
                  endcase
               end
               1: b = 8'(8'h80 + 8'($urandom_range(0, 23)));
               2: b = 8'(8'h98 + 8'($urandom_range(0, 103)));
               3: b = 8'($urandom_range(0, 127));
               default: b = 8'($urandom);
            endcase
            step(1'b0, 1'b1, b);
         end
      end
      step(1'b0, 1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apu_reg_writer.md
# apu_reg_writer

Register-write front end for the APU triangle channel. Parses a two-byte write stream (address, then data) from the byte receiver, holds the triangle registers $4008/$400A/$400B, and issues the `reg_event` reload strobe those registers require. Also generates the quarter-frame `enable_240hz` tick, with a phase reset on writes to $4017. Sits between the serial byte receiver and the `triangle` channel.

## Interface
Parameters:
- `CLK_DIV`, 7457: clocks per `enable_240hz` tick (1.79 MHz / 240 Hz); legal range 2..65535.
- `TIMEOUT_CYCLES`, 4096: maximum clocks allowed between the address byte and the data byte; legal range 1..65535.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, 1.79 MHz tick domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `reg_4008`  out  8  linear counter / halt register.
- `reg_400A`  out  8  timer period low.
- `reg_400B`  out  8  length select / timer period high.
- `reg_event`  out  1  one-cycle pulse after each $400B write.
- `enable_240hz`  out  1  one-cycle quarter-frame tick.
- `frame_error`  out  1  one-cycle pulse on a rejected byte or a timeout.

## Operation
- FSM with 2 states: `IDLE` and `DATA`.
- `IDLE`, with `rx_valid`:
  - If `rx_data[7]`=1 and `rx_data[6:0]` ≤ 0x17: latch the 5-bit offset `rx_data[4:0]`, load the timeout counter, go to `DATA`.
  - Otherwise: stay in `IDLE` and pulse `frame_error`.
- `DATA`, with `rx_valid`: accept any byte value as data, write it to the latched offset, go to `IDLE`.
- Offset decode:
  - 0x08 → `reg_4008`, 0x0A → `reg_400A`, 0x0B → `reg_400B` plus `reg_event`.
  - 0x17 → frame divider phase reset; data value discarded.
  - All other valid offsets: accepted and discarded, with no error.
- Timeout, in `DATA` without `rx_valid`: the counter decrements each cycle. When it reaches 0, go to `IDLE` and pulse `frame_error`.
- If `rx_valid` arrives in the same cycle the counter expires, the byte is accepted as data. The timeout is not reported.
- Frame divider: a 16-bit counter runs 0..`CLK_DIV`-1 and wraps to 0. `enable_240hz`=1 for the one cycle after the counter equals `CLK_DIV`-1.
- A $4017 data write forces the divider counter to 0. If this coincides with terminal count, the reset wins and no tick is issued for that period.
- Reset values: all registers 0x00, `reg_event`/`enable_240hz`/`frame_error` = 0, FSM = `IDLE`, divider counter = 0, timeout counter = 0.
- `rst` has priority over `rx_valid`. A reset while in `DATA` abandons the pending write.

## Timing
- Data byte strobe in cycle N:
  - The register holds the new value from cycle N+1.
  - `reg_event` is high in cycle N+1 only, coincident with the new `reg_400B`. The downstream length lookup therefore sees the new select in the same cycle.
- `frame_error` pulses in cycle N+1 for a rejected address byte in cycle N.
- Timeout is reported exactly `TIMEOUT_CYCLES` cycles after the address-byte cycle, provided no byte arrived.
- Back-to-back `rx_valid` on consecutive cycles is supported, with no dead cycle between frames.
- First `enable_240hz` after reset deassertion occurs in cycle `CLK_DIV` (the cycle counted after `rst` low = 1).
- All outputs are registered; no combinational path from input to output.

## Configuration
- `APU_RESYNC_TIMEOUT_EN` defined:
  - The timeout counter and the `DATA`→`IDLE` abort are present.
- `APU_RESYNC_TIMEOUT_EN` undefined:
  - No timeout counter is built, and `TIMEOUT_CYCLES` is ignored.
  - `DATA` waits indefinitely for the data byte.
  - `frame_error` is raised only by rejected address bytes.

## Test plan
- Reset then idle with `CLK_DIV`=8 → all registers 0; `enable_240hz` pulses in cycles 8, 16, 24; `reg_event` never asserts.
- Bytes 0x8B, 0x0D → `reg_400B`=0x0D; `reg_event` high for exactly one cycle, coincident with the new value. Then bytes 0x88, 0xFF → `reg_4008`=0xFF and no `reg_event`.
- Address-byte errors: byte 0x0B in `IDLE`, then 0x98 → two `frame_error` pulses; registers unchanged; FSM still `IDLE`.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): 0x8A, silence 16 cycles → `frame_error` at cycle 16. A following 0x55 is then treated as an address byte and rejected. Repeat with the data byte arriving at cycle 16 → `reg_400A`=0x55, no error.
- Divider reset (`CLK_DIV`=8): write 0x97, 0x00 with the data byte landing at terminal count → no tick that period; the next tick follows 8 cycles later.
- Reset while in `DATA`: 0x8B, then `rst` for 1 cycle, then 0x20 → 0x20 is rejected as an address byte; `reg_400B` stays 0x00; no `reg_event`.
